// File: rtl/router_fsm_nch.sv
`default_nettype none
// ============================================================================
// Module   : router_fsm_nch
// Brief    : Control FSM for a 1xN packet router. Decodes the header address,
//            sequences header/payload/parity loading into one of NUM_CH FIFOs,
//            stalls the source with busy, drops packets addressed to a missing
//            channel and drops packets whose wait-till-empty times out.
// Revision : 1.0 - initial release
// ============================================================================
module router_fsm_nch #(
  parameter int NUM_CH       = 3,
  parameter int ADDR_W       = 2,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic              drop_state,
  output logic [ADDR_W-1:0] addr_out,
  output logic              bad_addr,
  output logic              wait_timeout
);

  // Counter must hold 0..WAIT_TIMEOUT; keep at least one bit when disabled.
  localparam int c_wcnt_w = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam int c_to_last = (WAIT_TIMEOUT > 0) ? (WAIT_TIMEOUT - 1) : 0;
  localparam logic [c_wcnt_w-1:0] c_to_last_w = c_wcnt_w'(c_to_last);
  localparam bit c_to_en = (WAIT_TIMEOUT != 0);
  localparam int c_nslots = 2 ** ADDR_W;
  // One extra bit so NUM_CH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] c_num_ch = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [3:0] {
    S_DA   = 4'd0,
    S_LFD  = 4'd1,
    S_LD   = 4'd2,
    S_FFS  = 4'd3,
    S_LAF  = 4'd4,
    S_LP   = 4'd5,
    S_CPE  = 4'd6,
    S_WTE  = 4'd7,
    S_DROP = 4'd8
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [c_wcnt_w-1:0]   wcnt_q, wcnt_d;

  logic [c_nslots-1:0]   empty_ext;
  logic [c_nslots-1:0]   sr_ext;
  logic                  addr_valid;
  logic                  sr_hit;
  logic                  wait_hit;

  // Widen per-channel flags to the full address space so that any address,
  // including non-existent channels, indexes safely and reads as 0.
  always_comb begin
    empty_ext               = '0;
    sr_ext                  = '0;
    empty_ext[NUM_CH-1:0]   = fifo_empty;
    sr_ext[NUM_CH-1:0]      = soft_reset;
  end

  assign addr_valid = ({1'b0, data_in} < c_num_ch);
  assign sr_hit     = sr_ext[addr_q];
  assign wait_hit   = c_to_en && (wcnt_q == c_to_last_w);
  assign addr_out   = addr_q;

  // State, address latch and wait counter; reset first, then soft reset of
  // the channel currently being served.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_DA;
      addr_q  <= '0;
      wcnt_q  <= '0;
    end else if (sr_hit) begin
      state_q <= S_DA;
      addr_q  <= addr_d;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state decode plus the two event pulses.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wcnt_d       = '0;
    bad_addr     = 1'b0;
    wait_timeout = 1'b0;
    case (state_q)
      S_DA: begin
        addr_d = data_in;
        if (pkt_valid) begin
          if (!addr_valid) begin
            state_d  = S_DROP;
            bad_addr = 1'b1;
          end else if (empty_ext[data_in]) begin
            state_d = S_LFD;
          end else begin
            state_d = S_WTE;
          end
        end
      end
      S_LFD: state_d = S_LD;
      S_LD: begin
        if (fifo_full)       state_d = S_FFS;
        else if (!pkt_valid) state_d = S_LP;
      end
      S_FFS: begin
        if (!fifo_full) state_d = S_LAF;
      end
      S_LAF: begin
        if (parity_done)         state_d = S_DA;
        else if (!low_pkt_valid) state_d = S_LD;
        else                     state_d = S_LP;
      end
      S_LP:  state_d = S_CPE;
      S_CPE: state_d = fifo_full ? S_FFS : S_DA;
      S_WTE: begin
        wcnt_d = wcnt_q + 1'b1;
        if (empty_ext[addr_q]) begin
          state_d = S_LFD;
        end else if (wait_hit) begin
          state_d      = S_DROP;
          wait_timeout = 1'b1;
        end
      end
      S_DROP: begin
        if (!pkt_valid) state_d = S_DA;
      end
      default: state_d = S_DA;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    detect_add    = (state_q == S_DA);
    lfd_state     = (state_q == S_LFD);
    ld_state      = (state_q == S_LD);
    laf_state     = (state_q == S_LAF);
    full_state    = (state_q == S_FFS);
    rst_int_reg   = (state_q == S_CPE);
    drop_state    = (state_q == S_DROP);
    write_enb_reg = (state_q == S_LD) || (state_q == S_LAF) || (state_q == S_LP);
    busy          = (state_q == S_LFD) || (state_q == S_FFS) || (state_q == S_LAF) ||
                    (state_q == S_LP)  || (state_q == S_CPE) || (state_q == S_WTE);
  end

endmodule
`default_nettype wire
